// File: rtl/cordic_pkg.sv
// Shared constants, operand vector type and ID-width helper for the CORDIC issue scheduler.
package cordic_pkg;

  localparam int unsigned CORDIC_DATA_W = 32;
  // One pipeline stage per iteration, so this is also the default datapath latency.
  localparam int unsigned CORDIC_ITERS  = 10;

  typedef struct packed {
    logic [CORDIC_DATA_W-1:0] x;
    logic [CORDIC_DATA_W-1:0] y;
    logic [CORDIC_DATA_W-1:0] z;
  } cordic_vec_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned cordic_id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cordic_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among valid requesters, search starting after the last
// winner. The pointer advances only when a grant is actually issued.
module cordic_rr_arbiter
  import cordic_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W = cordic_id_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_any
);

  logic [ID_W-1:0] last_q;

  // Scan from last+1 so the most recent winner has the lowest priority next time.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      int unsigned idx;
      idx = 32'(last_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (en && !gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
        gnt_any  = 1'b1;
      end
    end
  end

  // Pointer register; reset to the top index so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= ID_W'(NUM_REQ - 1);
    end else if (gnt_any) begin
      last_q <= gnt_id;
    end
  end

endmodule

// File: rtl/cordic_scheduler.sv
// Shares one non-stallable, fully pipelined CORDIC datapath among NUM_REQ requesters.
// Operands are issued round-robin, one per cycle, and results return in issue order through a
// result FIFO. Issue is throttled by credits so the FIFO can never overflow.
// Optional feature: define CORDIC_SCHED_PERF_EN to add the perf_issued/perf_stall counters.
module cordic_scheduler
  import cordic_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_W     = CORDIC_DATA_W,
  parameter int unsigned PIPE_LAT   = CORDIC_ITERS,
  parameter int unsigned FIFO_DEPTH = 16,
  localparam int unsigned ID_W      = cordic_id_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  // Requester side
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_x,
  input  logic [NUM_REQ*DATA_W-1:0] req_y,
  input  logic [NUM_REQ*DATA_W-1:0] req_z,
  // Datapath side
  output logic [DATA_W-1:0]         pipe_x,
  output logic [DATA_W-1:0]         pipe_y,
  output logic [DATA_W-1:0]         pipe_z,
  input  logic [DATA_W-1:0]         pipe_xn,
  input  logic [DATA_W-1:0]         pipe_yn,
  input  logic [DATA_W-1:0]         pipe_zn,
  // Result channel
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DATA_W-1:0]         res_x,
  output logic [DATA_W-1:0]         res_y,
  output logic [DATA_W-1:0]         res_z,
  output logic [ID_W-1:0]           res_id
`ifdef CORDIC_SCHED_PERF_EN
  ,
  output logic [31:0]               perf_issued,
  output logic [31:0]               perf_stall
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned ENT_W = 3 * DATA_W + ID_W;

  // ---------------------------------------------------------------------------
  // Credits and arbitration
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]   outst_q, outst_d;
  logic               issue_ok;
  logic               accept;
  logic               pop;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;

  assign issue_ok = (outst_q < CNT_W'(FIFO_DEPTH));

  cordic_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (issue_ok & ~rst),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_any (accept)
  );

  assign req_ready = gnt;

  // Credit counter: accepted operations not yet popped from the result FIFO.
  always_comb begin
    outst_d = outst_q;
    case ({accept, pop})
      2'b10:   outst_d = outst_q + CNT_W'(1);
      2'b01:   outst_d = outst_q - CNT_W'(1);
      default: outst_d = outst_q;
    endcase
  end

  // Credit register.
  always_ff @(posedge clk) begin
    if (rst) begin
      outst_q <= '0;
    end else begin
      outst_q <= outst_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue register
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] sel_x, sel_y, sel_z;
  logic              iss_valid_q;
  logic [ID_W-1:0]   iss_id_q;
  logic [DATA_W-1:0] iss_x_q, iss_y_q, iss_z_q;

  // Operand mux for the granted requester.
  always_comb begin
    sel_x = req_x[32'(gnt_id) * DATA_W +: DATA_W];
    sel_y = req_y[32'(gnt_id) * DATA_W +: DATA_W];
    sel_z = req_z[32'(gnt_id) * DATA_W +: DATA_W];
  end

  // Operands hold when idle so the datapath inputs only move on an issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid_q <= 1'b0;
      iss_id_q    <= '0;
      iss_x_q     <= '0;
      iss_y_q     <= '0;
      iss_z_q     <= '0;
    end else begin
      iss_valid_q <= accept;
      if (accept) begin
        iss_id_q <= gnt_id;
        iss_x_q  <= sel_x;
        iss_y_q  <= sel_y;
        iss_z_q  <= sel_z;
      end
    end
  end

  assign pipe_x = iss_x_q;
  assign pipe_y = iss_y_q;
  assign pipe_z = iss_z_q;

  // ---------------------------------------------------------------------------
  // Tag pipe, aligned with the datapath stages
  // ---------------------------------------------------------------------------
  logic [PIPE_LAT-1:0] tag_v_q;
  logic [ID_W-1:0]     tag_id_q [PIPE_LAT];

  // Valid bits are reset so garbage left in the datapath after a reset is never captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v_q <= '0;
    end else begin
      tag_v_q[0] <= iss_valid_q;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
      end
    end
  end

  // ID payload shifts freely; it is only meaningful where the matching valid bit is set.
  always_ff @(posedge clk) begin
    tag_id_q[0] <= iss_id_q;
    for (int unsigned i = 1; i < PIPE_LAT; i++) begin
      tag_id_q[i] <= tag_id_q[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] fcnt_q;
  logic             fifo_we;
  logic             fifo_empty;
  logic             fifo_full;
  logic [ENT_W-1:0] wdata;
  logic [ENT_W-1:0] head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_we    = tag_v_q[PIPE_LAT-1];
  assign wdata      = {pipe_xn, pipe_yn, pipe_zn, tag_id_q[PIPE_LAT-1]};
  assign fifo_empty = (fcnt_q == '0);
  assign fifo_full  = (fcnt_q == CNT_W'(FIFO_DEPTH));
  assign res_valid  = ~fifo_empty;
  assign pop        = res_valid & res_ready;
  assign head       = mem_q[rd_ptr_q];

  // Pointers and occupancy; simultaneous read and write leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      if (fifo_we) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)     rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({fifo_we, pop})
        2'b10:   fcnt_q <= fcnt_q + CNT_W'(1);
        2'b01:   fcnt_q <= fcnt_q - CNT_W'(1);
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  // Storage array, no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (fifo_we) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Head entry drives the result; forced to zero while empty so stale storage never shows.
  always_comb begin
    res_x  = '0;
    res_y  = '0;
    res_z  = '0;
    res_id = '0;
    if (!fifo_empty) begin
      {res_x, res_y, res_z, res_id} = head;
    end
  end

  // Credits bound the in-flight count, so a write into a full FIFO means the throttle is broken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(fifo_we && fifo_full));
    end
  end

`ifdef CORDIC_SCHED_PERF_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic [31:0] perf_issued_q, perf_stall_q;
  logic        stall;

  assign stall = (|req_valid) & ~issue_ok;

  // Count accepts and credit-blocked cycles, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (accept && (perf_issued_q != '1)) perf_issued_q <= perf_issued_q + 32'd1;
      if (stall && (perf_stall_q != '1))   perf_stall_q  <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_cordic_scheduler.sv
// Randomized bench for cordic_scheduler: a transaction-level reference model predicts grants and
// pushes expected results into a scoreboard; a separate monitor checks the DUT against it.
module tb_cordic_scheduler;

  localparam int NUM_REQ    = 4;
  localparam int DATA_W     = 32;
  localparam int PIPE_LAT   = 10;
  localparam int FIFO_DEPTH = 16;
  localparam int ID_W       = 2;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_x = '0;
  logic [NUM_REQ*DATA_W-1:0] req_y = '0;
  logic [NUM_REQ*DATA_W-1:0] req_z = '0;
  logic [DATA_W-1:0]         pipe_x, pipe_y, pipe_z;
  logic [DATA_W-1:0]         pipe_xn, pipe_yn, pipe_zn;
  logic                      res_valid;
  logic                      res_ready = 1'b0;
  logic [DATA_W-1:0]         res_x, res_y, res_z;
  logic [ID_W-1:0]           res_id;
`ifdef CORDIC_SCHED_PERF_EN
  logic [31:0]               perf_issued, perf_stall;
`endif

  always #5 clk = ~clk;

  cordic_scheduler #(
    .NUM_REQ    (NUM_REQ),
    .DATA_W     (DATA_W),
    .PIPE_LAT   (PIPE_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_z       (req_z),
    .pipe_x      (pipe_x),
    .pipe_y      (pipe_y),
    .pipe_z      (pipe_z),
    .pipe_xn     (pipe_xn),
    .pipe_yn     (pipe_yn),
    .pipe_zn     (pipe_zn),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_x       (res_x),
    .res_y       (res_y),
    .res_z       (res_z),
    .res_id      (res_id)
`ifdef CORDIC_SCHED_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
`endif
  );

  // Stand-in datapath: a fixed mixing function followed by a PIPE_LAT-cycle delay.
  function automatic logic [DATA_W-1:0] fx(input logic [DATA_W-1:0] x, y, z);
    return x + y;
  endfunction
  function automatic logic [DATA_W-1:0] fy(input logic [DATA_W-1:0] x, y, z);
    return y ^ {z[15:0], z[31:16]} ^ {x[7:0], 24'h0};
  endfunction
  function automatic logic [DATA_W-1:0] fz(input logic [DATA_W-1:0] x, y, z);
    return z - x + 32'h9E3779B9;
  endfunction

  logic [DATA_W-1:0] dp_x [PIPE_LAT];
  logic [DATA_W-1:0] dp_y [PIPE_LAT];
  logic [DATA_W-1:0] dp_z [PIPE_LAT];

  always @(posedge clk) begin
    dp_x[0] <= fx(pipe_x, pipe_y, pipe_z);
    dp_y[0] <= fy(pipe_x, pipe_y, pipe_z);
    dp_z[0] <= fz(pipe_x, pipe_y, pipe_z);
    for (int k = 1; k < PIPE_LAT; k++) begin
      dp_x[k] <= dp_x[k-1];
      dp_y[k] <= dp_y[k-1];
      dp_z[k] <= dp_z[k-1];
    end
  end

  assign pipe_xn = dp_x[PIPE_LAT-1];
  assign pipe_yn = dp_y[PIPE_LAT-1];
  assign pipe_zn = dp_z[PIPE_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard entry: expected result words, issuing requester and first cycle it may appear.
  typedef struct {
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] z;
    int                id;
    int                rdy;
  } exp_t;

  exp_t               sb[$];
  exp_t               e;
  logic [NUM_REQ-1:0] exp_rdy = '0;
  int                 m_last = NUM_REQ - 1;
  int                 m_outst = 0;
  int                 m_issued = 0;
  int                 m_stall = 0;
  int                 pops = 0;
  int                 pops_seen = 0;
  int                 n_cmp = 0;
  int                 n_bad = 0;
  bit                 done = 1'b0;
  bit                 prev_rst = 1'b0;
  bit                 exp_v;

  // Reference model: credit count, round-robin choice and expected results, sampled mid-cycle.
  initial begin : predictor
    forever begin
      @(negedge clk);
      exp_rdy = '0;
      if (rst) begin
        m_last    = NUM_REQ - 1;
        m_outst   = 0;
        m_issued  = 0;
        m_stall   = 0;
        pops_seen = pops;
        sb.delete();
      end else begin
        // Pops from earlier cycles return credits now; this cycle's pop does not.
        m_outst   = m_outst - (pops - pops_seen);
        pops_seen = pops;
        if (m_outst < FIFO_DEPTH) begin
          bit found;
          found = 1'b0;
          for (int k = 1; k <= NUM_REQ; k++) begin
            int j;
            j = (m_last + k) % NUM_REQ;
            if (!found && req_valid[j]) begin
              logic [DATA_W-1:0] ox, oy, oz;
              found      = 1'b1;
              exp_rdy[j] = 1'b1;
              ox         = req_x[j*DATA_W +: DATA_W];
              oy         = req_y[j*DATA_W +: DATA_W];
              oz         = req_z[j*DATA_W +: DATA_W];
              e.x        = fx(ox, oy, oz);
              e.y        = fy(ox, oy, oz);
              e.z        = fz(ox, oy, oz);
              e.id       = j;
              e.rdy      = cyc + PIPE_LAT + 2;
              sb.push_back(e);
              m_last     = j;
              m_outst    = m_outst + 1;
              m_issued   = m_issued + 1;
            end
          end
        end else if (|req_valid) begin
          m_stall = m_stall + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares handshake and result outputs with the scoreboard, pops on consume.
  initial begin : monitor
    forever begin
      @(negedge clk);
      #1;
      if (done) begin
        chk("final_res_valid", 64'(res_valid), 64'(0));
        chk("final_sb_empty", 64'(sb.size()), 64'(0));
`ifdef CORDIC_SCHED_PERF_EN
        chk("perf_issued", 64'(perf_issued), 64'(m_issued));
        chk("perf_stall", 64'(perf_stall), 64'(m_stall));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (rst) begin
        prev_rst = 1'b1;
      end else begin
        if (prev_rst) begin
          chk("reset_res_valid", 64'(res_valid), 64'(0));
          chk("reset_res_x", 64'(res_x), 64'(0));
          chk("reset_res_y", 64'(res_y), 64'(0));
          chk("reset_res_z", 64'(res_z), 64'(0));
          chk("reset_res_id", 64'(res_id), 64'(0));
          chk("reset_pipe_x", 64'(pipe_x), 64'(0));
          chk("reset_pipe_y", 64'(pipe_y), 64'(0));
          chk("reset_pipe_z", 64'(pipe_z), 64'(0));
        end
        prev_rst = 1'b0;
        exp_v = 1'b0;
        if (sb.size() > 0) begin
          if (sb[0].rdy <= cyc) exp_v = 1'b1;
        end
        chk("res_valid", 64'(res_valid), 64'(exp_v));
        if (exp_v && res_valid) begin
          chk("res_x", 64'(res_x), 64'(sb[0].x));
          chk("res_y", 64'(res_y), 64'(sb[0].y));
          chk("res_z", 64'(res_z), 64'(sb[0].z));
          chk("res_id", 64'(res_id), 64'(sb[0].id));
          if (res_ready) begin
            void'(sb.pop_front());
            pops = pops + 1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_x[i*DATA_W +: DATA_W] = $urandom;
      req_y[i*DATA_W +: DATA_W] = $urandom;
      req_z[i*DATA_W +: DATA_W] = $urandom;
    end
  endtask

  task automatic run(input int n, input logic [NUM_REQ-1:0] v, input logic rr);
    for (int i = 0; i < n; i++) begin
      req_valid = v;
      res_ready = rr;
      rand_ops();
      tick();
    end
  endtask

  // Stimulus sequence.
  initial begin : driver
    rst       = 1'b1;
    req_valid = '0;
    res_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Single request from requester 2 with known operands.
    req_x = '0;
    req_y = '0;
    req_z = '0;
    req_x[2*DATA_W +: DATA_W] = 32'h26DD3B6A;
    req_z[2*DATA_W +: DATA_W] = 32'h20000000;
    req_valid = 4'b0100;
    res_ready = 1'b1;
    tick();
    req_valid = '0;
    repeat (15) tick();

    // Full load with a free-running consumer: one grant per cycle in rotation.
    run(40, 4'hF, 1'b1);
    // Consumer stalled: credits run out, then single pops release single accepts.
    run(30, 4'hF, 1'b0);
    run(1, 4'hF, 1'b1);
    run(5, 4'hF, 1'b0);
    run(1, 4'hF, 1'b1);
    run(3, 4'hF, 1'b0);
    // Full FIFO with steady pops and accepts across pointer wrap.
    run(50, 4'hF, 1'b1);

    // Mid-operation reset with work in flight and results queued.
    run(20, 4'h0, 1'b1);
    run(8, 4'hF, 1'b0);
    run(6, 4'h0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(20, 4'hF, 1'b1);

    // Random traffic and random backpressure.
    for (int i = 0; i < 400; i++) begin
      req_valid = NUM_REQ'($urandom);
      res_ready = ($urandom_range(0, 9) < 6);
      rand_ops();
      tick();
    end

    // Drain.
    run(40, 4'h0, 1'b1);
    done = 1'b1;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not reach its end within the time limit");
    $fatal(1, "timeout");
  end

endmodule
